phase_scheduler: RTL and testbench
==================================

# phase_scheduler

Time-slot scheduler that shares one downstream resource among up to eight requesters using the same one-hot ring-phase scheme as the team's octal counter/divider parts. A one-hot slot pointer walks a programmable-length ring. A requester whose slot is current receives an exclusive grant, and holds it until it releases or a hold limit expires. Sits between requesting sub-blocks and the shared resource; SLOT and CARRY_OUT also serve as a phase reference for downstream logic.

## Interface
- NUM_SLOTS, 8: ring size and width of REQ/GRANT/SLOT (legal 2..8).
- HOLD_MAX, 15: maximum consecutive grant cycles per grant (1..255).
- CLOCK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- INHIBIT  in  1  high freezes scanning (pointer hold, no new grants).
- LENGTH  in  3  active ring length minus one; slots 0..LENGTH are used.
- REQ  in  NUM_SLOTS  per-slot request, level-sensitive.
- GRANT  out  NUM_SLOTS  one-hot or zero; exclusive resource grant.
- SLOT  out  NUM_SLOTS  one-hot current pointer position.
- CARRY_OUT  out  1  high while pointer index ≤ LENGTH_q>>1.
- WRAP  out  1  one-cycle pulse when the pointer wraps to slot 0.
- TIMEOUT  out  1  one-cycle pulse on forced release.

## Operation
- Reset values: SLOT=…0001, GRANT=0, CARRY_OUT=1, WRAP=0, TIMEOUT=0, state=SCAN, hold count=0, LENGTH_q=LENGTH.
- LENGTH_q is sampled at reset and on every wrap. Mid-ring LENGTH changes take effect at the next wrap. Values ≥ NUM_SLOTS clamp to NUM_SLOTS-1.
- REQ bits above LENGTH_q are ignored.
- State SCAN with INHIBIT low:
  - If REQ[ptr] is high, go to GRANT and assert GRANT[ptr]; the pointer does not move.
  - Otherwise advance the pointer by one. The advance goes from LENGTH_q to 0 with WRAP=1.
- State SCAN with INHIBIT high: hold everything; WRAP=0.
- State GRANT: INHIBIT is ignored, and the hold counter increments each cycle.
  - If REQ[ptr] drops: clear GRANT, advance the pointer, return to SCAN.
  - If the counter reaches HOLD_MAX with REQ still high: clear GRANT, pulse TIMEOUT, advance the pointer, return to SCAN.
  - The counter clears on exit.
- Simultaneous REQ drop and HOLD_MAX: normal release, TIMEOUT stays 0.
- Only one grant at a time; GRANT never has two bits set.
- RESET overrides everything, including mid-grant. GRANT is low from the cycle after RESET is sampled.
- CARRY_OUT and WRAP are registered from the updated pointer.

## Timing
- Grant latency: REQ[ptr] sampled high in SCAN at edge t → GRANT high after edge t (one cycle).
- Release latency: REQ sampled low in GRANT at edge t → GRANT low and SLOT advanced after edge t.
- Maximum grant length: HOLD_MAX cycles.
- Idle pointer rate: one slot per CLOCK cycle while INHIBIT is low. With no requests, a full ring takes LENGTH_q+1 cycles.
- A released requester can be granted again only after the pointer returns to its slot (one full ring later).

## Configuration
- PHASE_SCHED_SKIP_EN defined:
  - In SCAN, if any enabled REQ is high, the pointer jumps in one cycle to the first requesting slot at or after ptr, searching circularly over 0..LENGTH_q, and GRANT asserts on that same edge.
  - A jump crossing LENGTH_q→0 pulses WRAP.
  - With no requests, the pointer steps by one as normal.
- Not defined: strict one-slot-per-cycle stepping as in Operation.

## Structure
- Shared package phase_sched_pkg holds:
  - state enum {SCAN, GRANT};
  - SLOT_IDX_W = 3;
  - HOLD_CNT_W = 8;
  - a function for circular next-requester search.
- One sub-module, slot_ring: the one-hot pointer with programmable length. It takes advance / jump-load inputs and produces SLOT, CARRY_OUT, WRAP and index. phase_scheduler contains the FSM, hold counter and grant logic.

## Test plan
- Reset, LENGTH=7, no REQ, INHIBIT=0 → SLOT walks 0x01…0x80 over 8 cycles. CARRY_OUT is high for slots 0-3 and low for slots 4-7. WRAP pulses on return to 0x01.
- REQ=0x04 held 3 cycles after its slot arrives → GRANT=0x04 one cycle after SLOT=0x04 for exactly 3 cycles, then SLOT=0x08. TIMEOUT=0.
- HOLD_MAX=15, REQ[1] held constantly → GRANT=0x02 for 15 cycles, TIMEOUT pulses once, SLOT=0x04. The next grant to slot 1 comes after a full ring.
- LENGTH changed 7→2 mid-ring, REQ[5] high → the ring finishes at slot 7, then cycles 0x01/0x02/0x04 only. REQ[5] is never granted.
- INHIBIT high for 4 cycles with REQ[3] high at the current slot → SLOT and GRANT frozen. Grant follows one cycle after INHIBIT falls. RESET during that grant → GRANT=0 and SLOT=0x01 the next cycle.
- With PHASE_SCHED_SKIP_EN, pointer at 0, REQ=0x40 → SLOT=0x40 and GRANT=0x40 after one edge. Without the macro, the grant comes after 7 cycles.

Source files
------------

// File: rtl/phase_sched_pkg.sv
// Shared types and helpers for the ring-phase scheduler.
// PHASE_SCHED_SKIP_EN (see phase_scheduler) uses next_req for pointer jumps.
package phase_sched_pkg;

  typedef enum logic {SCAN, GRANT} state_t;

  localparam int SLOT_IDX_W = 3;
  localparam int HOLD_CNT_W = 8;

  // Circular search over 0..len starting at start; returns {found, idx}.
  function automatic logic [SLOT_IDX_W:0] next_req(input logic [7:0] req,
                                                   input logic [SLOT_IDX_W-1:0] start,
                                                   input logic [SLOT_IDX_W-1:0] len);
    logic                  found;
    logic [SLOT_IDX_W-1:0] hit;
    logic [SLOT_IDX_W:0]   k;
    found = 1'b0;
    hit   = start;
    for (int i = 0; i < 8; i++) begin
      k = 4'(start) + 4'(i);
      if (k > 4'(len)) k = k - (4'(len) + 4'd1);
      if (!found && (4'(i) <= 4'(len)) && req[k[SLOT_IDX_W-1:0]]) begin
        found = 1'b1;
        hit   = k[SLOT_IDX_W-1:0];
      end
    end
    return {found, hit};
  endfunction

endpackage

// File: rtl/phase_scheduler_slot_ring.sv
// One-hot slot pointer over a programmable-length ring, with phase outputs.
// The active length is re-sampled only at reset and when the pointer wraps.
module slot_ring
  import phase_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [SLOT_IDX_W-1:0] length,
  input  logic                  advance,
  input  logic                  jump,
  input  logic [SLOT_IDX_W-1:0] jump_idx,
  output logic [NUM_SLOTS-1:0]  slot,
  output logic                  carry_out,
  output logic                  wrap,
  output logic [SLOT_IDX_W-1:0] idx,
  output logic [SLOT_IDX_W-1:0] len_q
);

  localparam logic [SLOT_IDX_W-1:0] LEN_MAX = SLOT_IDX_W'(NUM_SLOTS - 1);

  logic [SLOT_IDX_W-1:0] len_clamp, nxt_idx, nxt_len;
  logic                  nxt_wrap;

  assign len_clamp = (length > LEN_MAX) ? LEN_MAX : length;

  always_comb begin
    nxt_idx  = idx;
    nxt_wrap = 1'b0;
    if (jump) begin
      nxt_idx  = jump_idx;
      nxt_wrap = (jump_idx < idx);
    end else if (advance) begin
      if (idx >= len_q) begin
        nxt_idx  = '0;
        nxt_wrap = 1'b1;
      end else begin
        nxt_idx = idx + 1'b1;
      end
    end
    nxt_len = nxt_wrap ? len_clamp : len_q;
  end

  // Phase outputs are registered from the post-update pointer and length.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      idx       <= '0;
      len_q     <= len_clamp;
      slot      <= NUM_SLOTS'(1);
      carry_out <= 1'b1;
      wrap      <= 1'b0;
    end else begin
      idx       <= nxt_idx;
      len_q     <= nxt_len;
      slot      <= NUM_SLOTS'(8'd1 << nxt_idx);
      carry_out <= (nxt_idx <= (nxt_len >> 1));
      wrap      <= nxt_wrap;
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Time-slot scheduler: grants one requester at a time as the slot pointer walks the ring.
// Define PHASE_SCHED_SKIP_EN to let the pointer jump straight to the next requester.
module phase_scheduler
  import phase_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int HOLD_MAX  = 15
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  INHIBIT,
  input  logic [SLOT_IDX_W-1:0] LENGTH,
  input  logic [NUM_SLOTS-1:0]  REQ,
  output logic [NUM_SLOTS-1:0]  GRANT,
  output logic [NUM_SLOTS-1:0]  SLOT,
  output logic                  CARRY_OUT,
  output logic                  WRAP,
  output logic                  TIMEOUT
);

  state_t                state;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [SLOT_IDX_W-1:0] idx, len_q, jump_idx;
  logic [7:0]            mask8, req8;
  logic                  req_cur, cnt_hit, scan_go, release_now, advance, jump;

  always_comb begin
    mask8 = '0;
    for (int i = 0; i < 8; i++) mask8[i] = (3'(i) <= len_q);
  end

  assign req8        = 8'(REQ) & mask8;
  assign req_cur     = req8[idx];
  assign cnt_hit     = (hold_cnt + 8'd1) == HOLD_CNT_W'(HOLD_MAX);
  assign scan_go     = (state == phase_sched_pkg::SCAN) && !INHIBIT;
  assign release_now = (state == phase_sched_pkg::GRANT) && (!req_cur || cnt_hit);

`ifdef PHASE_SCHED_SKIP_EN
  logic [SLOT_IDX_W:0] search;
  assign search   = next_req(req8, idx, len_q);
  assign jump     = scan_go && !req_cur && search[SLOT_IDX_W];
  assign jump_idx = search[SLOT_IDX_W-1:0];
  assign advance  = (scan_go && !search[SLOT_IDX_W]) || release_now;
`else
  assign jump     = 1'b0;
  assign jump_idx = idx;
  assign advance  = (scan_go && !req_cur) || release_now;
`endif

  slot_ring #(.NUM_SLOTS(NUM_SLOTS)) u_ring (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .length    (LENGTH),
    .advance   (advance),
    .jump      (jump),
    .jump_idx  (jump_idx),
    .slot      (SLOT),
    .carry_out (CARRY_OUT),
    .wrap      (WRAP),
    .idx       (idx),
    .len_q     (len_q)
  );

  // jump_idx equals idx whenever no jump is taken, so it names the granted slot.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= phase_sched_pkg::SCAN;
      hold_cnt <= '0;
      GRANT    <= '0;
      TIMEOUT  <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        phase_sched_pkg::SCAN: begin
          if (scan_go && (req_cur || jump)) begin
            state <= phase_sched_pkg::GRANT;
            GRANT <= NUM_SLOTS'(8'd1 << jump_idx);
          end
        end
        phase_sched_pkg::GRANT: begin
          if (release_now) begin
            state    <= phase_sched_pkg::SCAN;
            GRANT    <= '0;
            hold_cnt <= '0;
            TIMEOUT  <= req_cur;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= phase_sched_pkg::SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler (default build, NUM_SLOTS=8, HOLD_MAX=15).
module tb_phase_scheduler;

  logic       CLOCK, RESET, INHIBIT, CARRY_OUT, WRAP, TIMEOUT;
  logic [2:0] LENGTH;
  logic [7:0] REQ, GRANT, SLOT;
  int total = 0;
  int bad   = 0;

  phase_scheduler #(.NUM_SLOTS(8), .HOLD_MAX(15)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .INHIBIT(INHIBIT), .LENGTH(LENGTH), .REQ(REQ),
    .GRANT(GRANT), .SLOT(SLOT), .CARRY_OUT(CARRY_OUT), .WRAP(WRAP), .TIMEOUT(TIMEOUT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    RESET = 1'b1; INHIBIT = 1'b0; LENGTH = 3'd7; REQ = 8'h00;
    step();
    chk("rst_slot", SLOT, 8'h01);
    chk("rst_grant", GRANT, 8'h00);
    chk("rst_carry", CARRY_OUT, 1'b1);
    chk("rst_wrap", WRAP, 1'b0);
    chk("rst_timeout", TIMEOUT, 1'b0);
    RESET = 1'b0;

    // Idle walk over the full ring
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("walk_slot", SLOT, 8'h01 << (k % 8));
      chk("walk_carry", CARRY_OUT, (k % 8) <= 3);
      chk("walk_wrap", WRAP, (k % 8) == 0);
    end

    // REQ[2] granted for three cycles, then released
    REQ = 8'h04;
    step(); step();
    chk("g2_slot_arrive", SLOT, 8'h04);
    chk("g2_grant_before", GRANT, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("g2_grant", GRANT, 8'h04);
      chk("g2_slot_hold", SLOT, 8'h04);
    end
    REQ = 8'h00;
    step();
    chk("g2_released", GRANT, 8'h00);
    chk("g2_slot_next", SLOT, 8'h08);
    chk("g2_timeout", TIMEOUT, 1'b0);

    // REQ[1] held: hold limit forces release, regrant one ring later
    REQ = 8'h02;
    n = 0;
    while (SLOT != 8'h02 && n < 16) begin step(); n++; end
    chk("g1_reach", SLOT, 8'h02);
    step();
    chk("g1_grant_first", GRANT, 8'h02);
    for (int k = 1; k < 15; k++) begin
      step();
      chk("g1_grant_hold", GRANT, 8'h02);
      chk("g1_no_timeout", TIMEOUT, 1'b0);
    end
    step();
    chk("g1_forced_release", GRANT, 8'h00);
    chk("g1_timeout", TIMEOUT, 1'b1);
    chk("g1_slot_after", SLOT, 8'h04);
    step();
    chk("g1_timeout_pulse", TIMEOUT, 1'b0);
    n = 1;
    while (GRANT != 8'h02 && n < 20) begin step(); n++; end
    chk("g1_regrant_cycles", n, 8);
    REQ = 8'h00;
    step();
    chk("g1_drop", GRANT, 8'h00);
    chk("g1_drop_slot", SLOT, 8'h04);

    // Shorten ring mid-way; REQ[5] lies outside the new length
    n = 0;
    while (SLOT != 8'h40 && n < 16) begin step(); n++; end
    chk("len_reach6", SLOT, 8'h40);
    LENGTH = 3'd2; REQ = 8'h20;
    step();
    chk("len_slot7", SLOT, 8'h80);
    chk("len_carry7", CARRY_OUT, 1'b0);
    step();
    chk("len_wrap_slot", SLOT, 8'h01);
    chk("len_wrap", WRAP, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("short_slot", SLOT, 8'h01 << (k % 3));
      chk("short_carry", CARRY_OUT, (k % 3) <= 1);
      chk("short_wrap", WRAP, (k % 3) == 0);
      chk("short_no_grant", GRANT, 8'h00);
    end

    // Inhibit freezes the pointer with REQ[3] pending; reset mid-grant
    LENGTH = 3'd7; REQ = 8'h00;
    n = 0;
    while (SLOT != 8'h08 && n < 20) begin step(); n++; end
    chk("inh_reach3", SLOT, 8'h08);
    INHIBIT = 1'b1; REQ = 8'h08;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("inh_slot", SLOT, 8'h08);
      chk("inh_grant", GRANT, 8'h00);
      chk("inh_wrap", WRAP, 1'b0);
    end
    INHIBIT = 1'b0;
    step();
    chk("inh_grant_after", GRANT, 8'h08);
    chk("inh_slot_after", SLOT, 8'h08);
    RESET = 1'b1;
    step();
    chk("midrst_grant", GRANT, 8'h00);
    chk("midrst_slot", SLOT, 8'h01);
    chk("midrst_carry", CARRY_OUT, 1'b1);
    RESET = 1'b0;

    // Far slot without skip: 7 edges to grant; then drop exactly at hold limit
    REQ = 8'h40;
    n = 0;
    while (GRANT != 8'h40 && n < 20) begin step(); n++; end
    chk("far_grant_cycles", n, 7);
    chk("far_slot", SLOT, 8'h40);
    for (int k = 1; k < 15; k++) step();
    chk("edge_grant_held", GRANT, 8'h40);
    REQ = 8'h00;
    step();
    chk("edge_release", GRANT, 8'h00);
    chk("edge_no_timeout", TIMEOUT, 1'b0);
    chk("edge_slot", SLOT, 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
